// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU types for the fetch/sequencing front end of the single-cycle MIPS datapath.
// Holds the word type, the fetch FSM encoding and the instruction field geometry.
package fetch_sequencer_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t       PC_STEP    = 32'd4;
    localparam int unsigned J_TARGET_W = 26;
    localparam int unsigned IMM_W      = 16;

    // Sign-extended 16-bit immediate turned into a byte offset (word index << 2).
    function automatic word_t branch_offset(input logic [IMM_W-1:0] imm);
        return {{(32 - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_npc_calc.sv
// Combinational next-PC selection: jr > j/jal > taken branch > pc+4.
// Only the low 26 instruction bits carry jump targets and branch immediates.
module npc_calc
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0]           pc,
    input  logic [J_TARGET_W-1:0] instr,
    input  logic                  branchEq,
    input  logic                  branchNe,
    input  logic                  jump,
    input  logic                  jumpr,
    input  logic                  zero,
    input  logic [31:0]           rs_data,
    output logic [31:0]           next_pc,
    output logic [31:0]           pc_plus4
);

    logic  taken;
    word_t branch_target;
    word_t jump_target;
    word_t jumpr_target;

    assign pc_plus4      = pc + PC_STEP;
    assign taken         = (branchEq & zero) | (branchNe & ~zero);
    assign branch_target = pc_plus4 + branch_offset(instr[IMM_W-1:0]);
    assign jump_target   = {pc_plus4[31:28], instr, 2'b00};
    assign jumpr_target  = rs_data & ~32'h3;

    always_comb begin
        // NOTE: default first so every path assigns next_pc and no latch is inferred.
        next_pc = pc_plus4;
        if (jumpr)
            next_pc = jumpr_target;
        else if (jump)
            next_pc = jump_target;
        else if (taken)
            next_pc = branch_target;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, the instruction-fetch handshake, the held instruction and the
// data-memory sequencing for one instruction at a time; latches halt.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] PC_INIT      = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        branchEq,
    input  logic        branchNe,
    input  logic        jump,
    input  logic        jumpr,
    input  logic        halt,
    input  logic        memToReg,
    input  logic        memW,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic        dhit,
    output logic        dREN,
    output logic        dWEN,
    output logic        wb_en,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        err
);

    fetch_state_t state;
    word_t        next_pc;
    logic [31:0]  tmo_cnt;
    logic [31:0]  tmo_next;
    logic         in_exec;
    logic         done;

    npc_calc u_npc (
        .pc       (pc),
        .instr    (instr[J_TARGET_W-1:0]),
        .branchEq (branchEq),
        .branchNe (branchNe),
        .jump     (jump),
        .jumpr    (jumpr),
        .zero     (zero),
        .rs_data  (rs_data),
        .next_pc  (next_pc),
        .pc_plus4 (pc_plus4)
    );

    assign in_exec  = (state == EXEC);
    // Memory ops finish on dhit; everything else completes in its first EXEC cycle.
    assign done     = ~(memToReg | memW) | dhit;
    assign tmo_next = tmo_cnt + 32'd1;

    assign iREN        = nRST & (state == FETCH);
    assign iaddr       = pc;
    assign instr_valid = in_exec;
    assign dREN        = in_exec & memToReg;
    assign dWEN        = in_exec & memW;
    assign wb_en       = in_exec & done & ~halt;
    assign halted      = (state == HALTED);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            instr   <= '0;
            err     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        instr   <= iload;
                        tmo_cnt <= '0;
                        state   <= EXEC;
                    end else begin
                        if (tmo_cnt != '1)
                            tmo_cnt <= tmo_next;
                        // err is sticky; fetching carries on regardless.
                        if (IMEM_TIMEOUT != 0 && tmo_next == 32'(IMEM_TIMEOUT))
                            err <= 1'b1;
                    end
                end
                EXEC: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (done) begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed PCs for sequential, branch,
// jump, jr, load-wait, halt, async reset, fetch timeout and PC wrap cases.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        branchEq, branchNe, jump, jumpr, halt, memToReg, memW, zero;
    logic [31:0] rs_data;
    logic        dhit;
    logic        dREN, dWEN, wb_en;
    logic [31:0] pc, pc_plus4;
    logic        halted, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fetch_sequencer #(
        .PC_INIT      (32'h0000_0000),
        .IMEM_TIMEOUT (8)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .iload       (iload),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .branchEq    (branchEq),
        .branchNe    (branchNe),
        .jump        (jump),
        .jumpr       (jumpr),
        .halt        (halt),
        .memToReg    (memToReg),
        .memW        (memW),
        .zero        (zero),
        .rs_data     (rs_data),
        .dhit        (dhit),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .wb_en       (wb_en),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Land 1 ns after the rising edge; inputs change here, outputs are read 2 ns later.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_flags();
        branchEq = 0; branchNe = 0; jump = 0; jumpr = 0; halt = 0;
        memToReg = 0; memW = 0; zero = 0; rs_data = '0; dhit = 0;
    endtask

    // Idle `gap` FETCH cycles, then return word w; leaves the DUT in EXEC.
    task automatic fetch_word(input logic [31:0] w, input int gap, input logic [31:0] exp_addr);
        ihit  = 0;
        iload = '0;
        repeat (gap) cycle();
        settle();
        check("fetch iREN", 32'(iREN), 32'd1);
        check("fetch iaddr", iaddr, exp_addr);
        ihit  = 1;
        iload = w;
        cycle();
        ihit  = 0;
        iload = '0;
        settle();
        check("instr latched", instr, w);
        check("instr_valid", 32'(instr_valid), 32'd1);
    endtask

    // Fetch a nop at cur and retire it as a jr to target.
    task automatic jr_to(input logic [31:0] target, input logic [31:0] cur);
        fetch_word(32'h0, 0, cur);
        jumpr   = 1;
        rs_data = target;
        cycle();
        clear_flags();
        settle();
        check("jr_to pc", pc, target);
    endtask

    initial begin
        nRST  = 0;
        ihit  = 0;
        iload = '0;
        clear_flags();
        repeat (2) @(posedge CLK);
        #1;
        check("reset iREN", 32'(iREN), 32'd0);
        check("reset dREN", 32'(dREN), 32'd0);
        check("reset pc", pc, 32'h0);
        check("reset instr", instr, 32'h0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset instr_valid", 32'(instr_valid), 32'd0);

        // Sequential fetch of addiu after two idle cycles.
        nRST = 1;
        fetch_word(32'h2401_0005, 2, 32'h0);
        check("addiu wb_en", 32'(wb_en), 32'd1);
        check("addiu pc_plus4", pc_plus4, 32'h4);
        cycle();
        settle();
        check("seq iaddr", iaddr, 32'h4);
        check("seq iREN", 32'(iREN), 32'd1);
        check("seq instr_valid", 32'(instr_valid), 32'd0);

        // BEQ -2 taken from 0x10, then not taken.
        jr_to(32'h10, 32'h4);
        fetch_word(32'h1000_FFFE, 0, 32'h10);
        branchEq = 1;
        zero     = 1;
        cycle();
        clear_flags();
        settle();
        check("beq taken pc", pc, 32'h0C);
        jr_to(32'h10, 32'h0C);
        fetch_word(32'h1000_FFFE, 0, 32'h10);
        branchEq = 1;
        zero     = 0;
        cycle();
        clear_flags();
        settle();
        check("beq not taken pc", pc, 32'h14);

        // JAL at 0x40, then jr 0x47 with lower-priority jump/branch also raised.
        jr_to(32'h40, 32'h14);
        fetch_word(32'h0C00_0100, 0, 32'h40);
        jump = 1;
        settle();
        check("jal pc_plus4", pc_plus4, 32'h44);
        cycle();
        clear_flags();
        settle();
        check("jal pc", pc, 32'h400);
        fetch_word(32'h0, 0, 32'h400);
        jumpr    = 1;
        jump     = 1;
        branchEq = 1;
        zero     = 1;
        rs_data  = 32'h47;
        cycle();
        clear_flags();
        settle();
        check("jr priority pc", pc, 32'h44);

        // LW with dhit on the third EXEC cycle.
        fetch_word(32'h8C22_0000, 0, 32'h44);
        memToReg = 1;
        for (int i = 0; i < 3; i++) begin
            dhit = (i == 2);
            settle();
            check($sformatf("lw dREN c%0d", i), 32'(dREN), 32'd1);
            check($sformatf("lw dWEN c%0d", i), 32'(dWEN), 32'd0);
            check($sformatf("lw wb_en c%0d", i), 32'(wb_en), (i == 2) ? 32'd1 : 32'd0);
            check($sformatf("lw pc c%0d", i), pc, 32'h44);
            cycle();
        end
        clear_flags();
        settle();
        check("lw pc after dhit", pc, 32'h48);
        check("lw dREN after", 32'(dREN), 32'd0);

        // Halt: frozen for 10 cycles even with ihit offered.
        fetch_word(32'hFFFF_FFFF, 0, 32'h48);
        halt = 1;
        settle();
        check("halt wb_en", 32'(wb_en), 32'd0);
        cycle();
        halt  = 0;
        ihit  = 1;
        iload = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("halted c%0d", i), 32'(halted), 32'd1);
            check($sformatf("halted iREN c%0d", i), 32'(iREN), 32'd0);
            check($sformatf("halted pc c%0d", i), pc, 32'h48);
            cycle();
        end
        ihit  = 0;
        iload = '0;
        settle();
        check("halted instr held", instr, 32'hFFFF_FFFF);

        // Asynchronous reset mid-cycle.
        #2;
        nRST = 0;
        #1;
        check("async rst pc", pc, 32'h0);
        check("async rst halted", 32'(halted), 32'd0);
        check("async rst instr", instr, 32'h0);
        check("async rst iREN", 32'(iREN), 32'd0);
        cycle();
        nRST = 1;
        settle();
        check("post rst iREN", 32'(iREN), 32'd1);
        check("post rst iaddr", iaddr, 32'h0);

        // Fetch timeout: err after 8 ihit-less FETCH cycles, sticky thereafter.
        for (int i = 1; i <= 7; i++) begin
            cycle();
            settle();
            check($sformatf("err clear c%0d", i), 32'(err), 32'd0);
        end
        cycle();
        settle();
        check("err set c8", 32'(err), 32'd1);
        check("err fetch continues", 32'(iREN), 32'd1);
        fetch_word(32'h0, 3, 32'h0);
        cycle();
        settle();
        check("err sticky", 32'(err), 32'd1);
        check("nop pc", pc, 32'h4);

        // PC wrap from 0xFFFF_FFFC on a nop.
        jr_to(32'hFFFF_FFFC, 32'h4);
        fetch_word(32'h0, 0, 32'hFFFF_FFFC);
        check("wrap pc_plus4", pc_plus4, 32'h0);
        check("wrap wb_en", 32'(wb_en), 32'd1);
        cycle();
        settle();
        check("wrap pc", pc, 32'h0);
        check("err still set", 32'(err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
